step_clk_ctrl: RTL and testbench

STEP_CLK_CTRL -- requirements
Module: step_clk_ctrl

---
 rtl/step_clk_ctrl.sv | 114 +++++++++++
 tb/tb_step_clk_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_clk_ctrl.sv
// Step/run clock-enable generator: a programmable divider that issues tick pulses
// (and a toggling divided clock) either free-running or for a counted burst.
module step_clk_ctrl #(
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             stop,
    output logic             tick,
    output logic             clkout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [CNT_W-1:0] rem_reg;
    logic             clkout_reg;
    logic             done_reg;

    logic [DIV_W-1:0] div_eff;
    logic             at_wrap;
    logic             accept;

    // A programmed divisor of zero behaves as one: tick on every busy cycle.
    assign div_eff   = (div_reg == '0) ? DIV_W'(1) : div_reg;
    assign at_wrap   = (cnt_reg == div_eff - DIV_W'(1));
    assign busy      = (state_reg != IDLE);
    assign cmd_ready = (state_reg == IDLE) && !stop;
    assign accept    = cmd_valid && cmd_ready;
    // tick is combinational so that stop can suppress it within the same cycle.
    assign tick      = busy && at_wrap && !stop;
    assign clkout    = clkout_reg;
    assign done      = done_reg;
    assign remaining = rem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            div_reg    <= DIV_W'(DIV_RST);
            cnt_reg    <= '0;
            rem_reg    <= '0;
            clkout_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Divisor is frozen while busy; an update alongside an accept takes effect for it.
            if (state_reg == IDLE && cfg_we) begin
                div_reg <= cfg_div;
            end
            if (tick) begin
                clkout_reg <= ~clkout_reg;
            end
            if (stop) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                rem_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        cnt_reg <= '0;
                        if (accept) begin
                            if (!cmd_op) begin
                                state_reg <= RUN;
                            end else if (cmd_count == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= STEP;
                                rem_reg   <= cmd_count;
                            end
                        end
                    end
                    RUN: begin
                        cnt_reg <= at_wrap ? '0 : cnt_reg + DIV_W'(1);
                    end
                    STEP: begin
                        cnt_reg <= at_wrap ? '0 : cnt_reg + DIV_W'(1);
                        if (tick) begin
                            if (rem_reg <= CNT_W'(1)) begin
                                state_reg <= IDLE;
                                rem_reg   <= '0;
                                done_reg  <= 1'b1;
                            end else begin
                                rem_reg <= rem_reg - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        rem_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed bench for step_clk_ctrl: hand-computed tick positions, remaining counts,
// done pulses and clkout levels for RUN, STEP, stop, divisor update and reset cases.
module tb_step_clk_ctrl;

    localparam int DIV_W = 26;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [DIV_W-1:0] cfg_div;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             stop;
    logic             tick;
    logic             clkout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    step_clk_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RST(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_div   (cfg_div),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .stop      (stop),
        .tick      (tick),
        .clkout    (clkout),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one accepting edge; on return we are in the first cycle after it.
    task automatic issue(input logic op, input logic [CNT_W-1:0] cnt,
                         input logic we, input logic [DIV_W-1:0] dv);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cfg_we    = we;
        cfg_div   = dv;
        #1;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        cfg_we    = 1'b0;
        $display("txn %s count=%0d cfg_we=%0d div=%0d", op ? "STEP" : "RUN", cnt, we, dv);
    endtask

    task automatic write_div(input logic [DIV_W-1:0] dv);
        cfg_we  = 1'b1;
        cfg_div = dv;
        cyc();
        cfg_we  = 1'b0;
        $display("txn CFG div=%0d", dv);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        #1;
        chk("stop_tick_low", 32'(tick), 32'd0);
        chk("stop_cmd_ready_low", 32'(cmd_ready), 32'd0);
        cyc();
        stop = 1'b0;
        #1;
        chk("stop_busy_low", 32'(busy), 32'd0);
        chk("stop_done_low", 32'(done), 32'd0);
        $display("txn STOP");
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_div = '0; cmd_valid = 1'b0;
        cmd_op = 1'b0; cmd_count = '0; stop = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cyc();

        // RUN with default divisor 20: ticks at busy cycles 20,40,60; clkout period 40.
        issue(1'b0, '0, 1'b0, '0);
        for (int k = 1; k <= 60; k++) begin
            chk("run20_tick", 32'(tick), 32'((k % 20) == 0));
            chk("run20_clkout", 32'(clkout), 32'(((k - 1) / 20) % 2));
            chk("run20_busy", 32'(busy), 32'd1);
            cyc();
        end
        // Now in cycle 61: clkout has toggled three times.
        chk("run20_clkout_pre_stop", 32'(clkout), 32'd1);
        do_stop();
        chk("run20_clkout_held", 32'(clkout), 32'd1);

        // STEP 4 with divisor 3: ticks at 3,6,9,12; done at 13.
        write_div(3);
        issue(1'b1, 16'd4, 1'b0, '0);
        for (int k = 1; k <= 12; k++) begin
            chk("step4_tick", 32'(tick), 32'((k % 3) == 0));
            chk("step4_remaining", 32'(remaining), 32'(4 - (k - 1) / 3));
            chk("step4_done", 32'(done), 32'd0);
            chk("step4_busy", 32'(busy), 32'd1);
            if (k == 4) chk("step4_clkout_after_1st", 32'(clkout), 32'd0);
            cyc();
        end
        chk("step4_done_pulse", 32'(done), 32'd1);
        chk("step4_busy_fall", 32'(busy), 32'd0);
        chk("step4_remaining_zero", 32'(remaining), 32'd0);
        chk("step4_clkout_even", 32'(clkout), 32'd1);
        cyc();
        chk("step4_done_one_cycle", 32'(done), 32'd0);

        // STEP with count 0: no busy, no tick, done one cycle after acceptance.
        issue(1'b1, 16'd0, 1'b0, '0);
        chk("step0_busy", 32'(busy), 32'd0);
        chk("step0_tick", 32'(tick), 32'd0);
        chk("step0_done", 32'(done), 32'd1);
        cyc();
        chk("step0_done_clear", 32'(done), 32'd0);

        // Divisor 0 behaves as 1: tick every cycle, then stop on a tick cycle.
        write_div(0);
        issue(1'b0, '0, 1'b0, '0);
        for (int k = 1; k <= 5; k++) begin
            chk("div0_tick", 32'(tick), 32'd1);
            chk("div0_clkout", 32'(clkout), 32'(k % 2));
            cyc();
        end
        chk("div0_clkout_pre_stop", 32'(clkout), 32'd0);
        do_stop();
        chk("div0_clkout_held", 32'(clkout), 32'd0);
        cyc();
        chk("div0_idle_tick", 32'(tick), 32'd0);
        chk("div0_idle_clkout", 32'(clkout), 32'd0);

        // STEP 3 at divisor 5 with a cfg write of 7 mid-burst that must be ignored.
        issue(1'b1, 16'd3, 1'b1, 26'd5);
        for (int k = 1; k <= 15; k++) begin
            if (k == 2) begin
                cfg_we  = 1'b1;
                cfg_div = 26'd7;
            end else begin
                cfg_we = 1'b0;
            end
            chk("div5_tick", 32'(tick), 32'((k % 5) == 0));
            chk("div5_remaining", 32'(remaining), 32'(3 - (k - 1) / 5));
            cyc();
        end
        chk("div5_done", 32'(done), 32'd1);
        // RUN with simultaneous cfg write 7 applies to this command.
        issue(1'b0, '0, 1'b1, 26'd7);
        for (int k = 1; k <= 14; k++) begin
            chk("div7_tick", 32'(tick), 32'((k % 7) == 0));
            cyc();
        end
        do_stop();

        // Reset mid-STEP with remaining 9 (divisor 1, count 12).
        issue(1'b1, 16'd12, 1'b1, 26'd1);
        cyc(); cyc(); cyc();
        chk("rst_mid_remaining_before", 32'(remaining), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_remaining", 32'(remaining), 32'd0);
        chk("rst_mid_tick", 32'(tick), 32'd0);
        chk("rst_mid_clkout", 32'(clkout), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_mid_no_done", 32'(done), 32'd0);
        chk("rst_mid_stays_idle", 32'(busy), 32'd0);
        $display("txn RESET");
        // Divisor back to 20: first tick 20 cycles after acceptance.
        issue(1'b0, '0, 1'b0, '0);
        for (int k = 1; k <= 20; k++) begin
            chk("post_rst_div20_tick", 32'(tick), 32'(k == 20));
            cyc();
        end
        do_stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
